// File: rtl/block_nest_checker.sv
// Streaming begin/end + fork/join nesting checker with a typed stack.
module block_nest_checker #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned CASE_INSENS = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [7:0]                   in,
   output logic                         result,
   output logic                         error,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic [4:0]                   st,
   output logic [CNT_W-1:0]             cnt
);

   localparam int unsigned DW = $clog2(DEPTH + 1);

   typedef enum logic [4:0] {
      IDLE = 5'd0,
      B1, B2, B3, B4, B5,
      E1, E2, E3,
      F1, F2, F3, F4,
      J1, J2, J3, J4,
      SKIP
   } state_t;

   state_t             st_q, st_d;
   logic [DEPTH-1:0]   stack_q, stack_d;
   logic [DW-1:0]      depth_q, depth_d;
   logic               error_q, error_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [7:0]         ch;
   logic               is_space;
   logic               push, pop, push_type, exp_type, top_type;

   // Optional A-Z to a-z fold before matching
   always_comb begin
      ch = in;
      if (CASE_INSENS != 0 && in >= 8'h41 && in <= 8'h5A) ch = in + 8'h20;
      is_space = (ch == 8'h20);
   end

   // Word matcher next state; a space always returns to IDLE
   always_comb begin
      st_d = st_q;
      if (in_valid) begin
         if (is_space) begin
            st_d = IDLE;
         end else begin
            st_d = SKIP;
            case (st_q)
               IDLE: begin
                  if      (ch == 8'h62) st_d = B1;
                  else if (ch == 8'h65) st_d = E1;
                  else if (ch == 8'h66) st_d = F1;
                  else if (ch == 8'h6A) st_d = J1;
               end
               B1: if (ch == 8'h65) st_d = B2;
               B2: if (ch == 8'h67) st_d = B3;
               B3: if (ch == 8'h69) st_d = B4;
               B4: if (ch == 8'h6E) st_d = B5;
               E1: if (ch == 8'h6E) st_d = E2;
               E2: if (ch == 8'h64) st_d = E3;
               F1: if (ch == 8'h6F) st_d = F2;
               F2: if (ch == 8'h72) st_d = F3;
               F3: if (ch == 8'h6B) st_d = F4;
               J1: if (ch == 8'h6F) st_d = J2;
               J2: if (ch == 8'h69) st_d = J3;
               J3: if (ch == 8'h6E) st_d = J4;
               default: st_d = SKIP;
            endcase
         end
      end
   end

   // Token decode on the committing space; type 0 = begin/end, 1 = fork/join
   always_comb begin
      push      = in_valid && is_space && (st_q == B5 || st_q == F4);
      pop       = in_valid && is_space && (st_q == E3 || st_q == J4);
      push_type = (st_q == F4);
      exp_type  = (st_q == J4);
   end

   // Stack top lookup
   always_comb begin
      top_type = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (DW'(i + 1) == depth_q) top_type = stack_q[i];
   end

   // Stack, depth, sticky error and saturating token counter updates
   always_comb begin
      stack_d = stack_q;
      depth_d = depth_q;
      error_d = error_q;
      cnt_d   = cnt_q;
      if ((push || pop) && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (!error_q) begin
         if (push) begin
            if (depth_q == DW'(DEPTH)) begin
               error_d = 1'b1;
            end else begin
               for (int unsigned i = 0; i < DEPTH; i++)
                  if (DW'(i) == depth_q) stack_d[i] = push_type;
               depth_d = depth_q + DW'(1);
            end
         end else if (pop) begin
            if (depth_q == '0 || top_type != exp_type) error_d = 1'b1;
            else depth_d = depth_q - DW'(1);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q    <= IDLE;
         stack_q <= '0;
         depth_q <= '0;
         error_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         st_q    <= st_d;
         stack_q <= stack_d;
         depth_q <= depth_d;
         error_q <= error_d;
         cnt_q   <= cnt_d;
      end
   end

   assign st     = st_q;
   assign depth  = depth_q;
   assign error  = error_q;
   assign cnt    = cnt_q;
   assign result = (depth_q == '0) && !error_q;

endmodule

// File: doc/block_nest_checker.md
Name: block_nest_checker

Overview:
- Streaming keyword-nesting checker; successor to the single-pair begin/end checker.
- Consumes one ASCII byte per valid cycle and tokenises words on space (0x20).
- Tracks two keyword pairs, begin/end and fork/join, with proper nesting on a parametrised-depth type stack, plus optional case folding.
- Reports balance, a sticky error, current depth and a keyword count. Sits behind the character source in the text-checker datapath.

Parameters:
DEPTH, 16, maximum nesting depth (stack entries), >=2
CNT_W, 32, width of keyword counter
CASE_INSENS, 1, 1: fold A-Z to a-z before matching; 0: lowercase-only keywords

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  byte on `in` is consumed this cycle when 1
in  input  8  ASCII byte
result  output  1  1 when committed stack is empty and error==0
error  output  1  sticky: underflow, mismatch or overflow seen
depth  output  $clog2(DEPTH+1)  committed stack occupancy
st  output  5  word-matcher state (debug)
cnt  output  CNT_W  committed keyword tokens, saturating at all-ones

Behaviour:
- Reset (reset==0, asynchronous): st=IDLE(0), depth=0, error=0, cnt=0, stack cleared, result=1. Release takes effect at the next clk edge. Reset mid-word discards the partial word.
- All state is updated only on clk edges with in_valid==1. With in_valid==0, everything holds and `in` is ignored.
- Case folding: when CASE_INSENS==1, 0x41-0x5A map to +0x20 before matching. No other bytes are affected.
- Matcher states: IDLE; B1..B5 (b,be,beg,begi,begin); E1..E3 (e,en,end); F1..F4 (f,fo,for,fork); J1..J4 (j,jo,joi,join); SKIP. Encoding is free, but IDLE must be 0.
- Non-space byte transitions:
  - From IDLE: b->B1, e->E1, f->F1, j->J1, anything else->SKIP.
  - From a partial state: the expected next letter advances the state; any other byte goes to SKIP.
  - From a full-match state (B5, E3, F4, J4) any non-space byte goes to SKIP, so "endd" is not a keyword.
  - SKIP stays in SKIP.
- Space byte: commits the word and sets st to IDLE. Only B5, E3, F4 and J4 commit a token; all other states commit nothing. Consecutive spaces are no-ops.
- Commit actions, applied on the edge that samples the space; outputs are registered and visible right after that edge:
  - begin: push type 0. fork: push type 1.
  - end: pop, expecting type 0. join: pop, expecting type 1.
  - cnt increments on every committed token, including erroring ones, and saturates.
- Errors:
  - Underflow: pop with depth==0.
  - Mismatch: popped type differs from the expected type.
  - Overflow: push with depth==DEPTH.
  - On any error: error<=1, and the stack and depth are frozen at their pre-error values.
- After error==1:
  - The stack never changes again until reset.
  - The matcher and cnt keep running.
  - result stays 0.
- result is combinational from registered state: (depth==0)&&!error.
- Latency: one cycle from the sampled space to updated depth, error and result. st updates one cycle after each sampled byte.
- A word still open at end of stream is never committed.

Test Plan:
- "begin fork join end " with CASE_INSENS=1 -> depth after each word's space: 1,2,1,0. result is 0 from the first space until the final space, then 1. cnt=4, error=0.
- "begin join " -> error=1 on the join's space edge, depth stays 1, result=0, cnt=2. A following "end " leaves depth=1 and error=1.
- "end begin endd word " -> underflow at the first space: error=1, depth=0, result=0. "endd" gives st=SKIP and no commit. Final cnt=2.
- "BeGiN EnD " -> with CASE_INSENS=1: result=1, cnt=2. With CASE_INSENS=0: no tokens, cnt=0, result=1.
- DEPTH=4 with six "begin " words -> depth 1,2,3,4 after the first four. Error=1 at the fifth, depth stays 4, cnt=6.
- "beg", then reset pulsed low mid-cycle, then "in  " -> all outputs return to reset values immediately. "in" goes to SKIP, no commit, cnt=0. In a separate run, in_valid=0 with in="e" for 3 cycles -> no state change.
